// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 HI/LO multiply/divide unit with its sequencing FSM for the MIPS pipeline.
// Latency: WIDTH+2 edges from start to done (2 edges for a zero divisor; shorter multiplies with early-out).
// Backpressure: stall holds new mul/div and HI/LO consumers/writers in EX while busy; no internal queuing.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, op, rs_val, rt_val  mul/div issue: op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   flush                   abandon current operation, HI/LO untouched
//   hi_we, lo_we, wdata     MTHI/MTLO writes (taken only when idle and not starting)
//   rd_hilo                 EX holds MFHI/MFLO
//   busy, stall, done, div0 status; done/div0 are one-cycle pulses
//   hi, lo                  architectural HI/LO registers
//
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies finish as soon as the
// remaining multiplier bits are all zero (including a zero multiplier at issue).

module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;

  // Multiply uses acc/mcand/mplier; divide reuses mplier as the quotient
  // shift register (initially holding the dividend) alongside rem/divisor.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   divisor;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               res_neg;
  logic               dvd_neg;
  logic               is_div0;

  // ---------------- issue-time operand conditioning ----------------
  logic             op_signed;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  assign op_signed = ~op[0];
  assign rs_neg    = op_signed & rs_val[WIDTH-1];
  assign rt_neg    = op_signed & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_val : rs_val;
  assign rt_mag    = rt_neg ? -rt_val : rt_val;

  // ---------------- per-iteration datapath ----------------
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier_shr;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH:0]     rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shr = mplier >> 1;

  // Restoring step: bring the next dividend bit into the partial remainder.
  // rem carries one extra bit so the shifted value never overflows.
  assign rem_sh  = {rem[WIDTH-1:0], mplier[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, divisor});
  assign rem_nxt = rem_ge ? (rem_sh - {1'b0, divisor}) : rem_sh;
  assign quo_nxt = {mplier[WIDTH-2:0], rem_ge};

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   rem_lo;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = res_neg ? -acc : acc;
  assign rem_lo   = rem[WIDTH-1:0];
  assign quo_fix  = res_neg ? -mplier : mplier;
  // Remainder follows the dividend's sign (truncating division).
  assign rem_fix  = dvd_neg ? -rem_lo : rem_lo;

  // Early-out decisions, resolved once here so the FSM stays build-agnostic.
  logic mul_zero_at_issue;
  logic mul_calc_exit;

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_zero_at_issue = (rt_val == '0);
  assign mul_calc_exit     = (cnt == '0) || (mplier_shr == '0);
`else
  assign mul_zero_at_issue = 1'b0;
  assign mul_calc_exit     = (cnt == '0);
`endif

  assign stall = busy & (start | rd_hilo | hi_we | lo_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      divisor <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      dvd_neg <= 1'b0;
      is_div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;

      // MTHI/MTLO only land while idle; busy is low in FIX-free cycles, so
      // these never collide with the result write below.
      if (!busy && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end

      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              is_div  <= op[1];
              res_neg <= rs_neg ^ rt_neg;
              dvd_neg <= rs_neg;
              is_div0 <= 1'b0;
              cnt     <= CNT_W'(WIDTH - 1);
              acc     <= '0;
              rem     <= '0;
              busy    <= 1'b1;
              if (op[1]) begin
                divisor <= rt_mag;
                mplier  <= rs_mag;
                mcand   <= '0;
                if (rt_val == '0) begin
                  // Zero divisor: raw dividend to HI, all ones to LO.
                  is_div0 <= 1'b1;
                  rem     <= {1'b0, rs_val};
                  mplier  <= '1;
                  state   <= FIX;
                end else begin
                  state   <= CALC;
                end
              end else begin
                divisor <= '0;
                mcand   <= {{WIDTH{1'b0}}, rs_mag};
                mplier  <= rt_mag;
                state   <= mul_zero_at_issue ? FIX : CALC;
              end
            end
          end

          CALC: begin
            cnt <= cnt - CNT_W'(1);
            if (is_div) begin
              rem    <= rem_nxt;
              mplier <= quo_nxt;
              if (cnt == '0) state <= FIX;
            end else begin
              acc    <= acc_nxt;
              mcand  <= mcand << 1;
              mplier <= mplier_shr;
              if (mul_calc_exit) state <= FIX;
            end
          end

          FIX: begin
            if (is_div0) begin
              hi <= rem_lo;
              lo <= mplier;
            end else if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done  <= 1'b1;
            div0  <= is_div0;
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO/div0,
// a monitor pops and compares on every done pulse.
// Latency/busy/stall/flush/reset behaviour is checked inline by the stimulus.

module tb_muldiv_sequencer;

  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         rd_hilo;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .flush   (flush),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .rd_hilo (rd_hilo),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .div0    (div0),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result hi", 64'(hi), 64'(e.hi));
        check("result lo", 64'(lo), 64'(e.lo));
        check("result div0", 64'(div0), 64'(e.div0));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Issue one op, wait for done, check latency (edges counted including the
  // start edge) and number of busy samples before done.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ed, input int exp_lat);
    int n;
    int bc;
    exp_t e;
    e.hi = eh; e.lo = el; e.div0 = ed;
    sb.push_back(e);
    model_hi = eh;
    model_lo = el;
    issue(o, a, b);
    n  = 1;
    bc = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
    end
    check({nm, " done seen"}, 64'(done), 64'(1));
    check({nm, " latency"}, 64'(n), 64'(exp_lat));
    check({nm, " busy cycles"}, 64'(bc), 64'(exp_lat - 1));
  endtask

  initial begin
    int n;
    logic saw_done;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_hilo = 1'b0;

    #12;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset div0", 64'(div0), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic vectors
    run_op("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    run_op("MULT -3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, EO ? 5 : 34);
    run_op("MULT maxpos x -1", 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, EO ? 3 : 34);
    run_op("MULTU 5x0", 2'b01, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, EO ? 2 : 34);
    run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("DIV 7/-2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34);
    run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    run_op("DIVU 100/0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2);
    run_op("DIV -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2);

    // MTHI then flushed MULTU: no done, HI/LO keep their values
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    model_hi = 32'h0000_1234;
    check("MTHI hi", 64'(hi), 64'(model_hi));
    issue(2'b01, 32'h0000_0005, 32'h0000_0006);
    repeat (9) begin @(posedge clk); #1; end
    check("busy before flush", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("busy after flush", 64'(busy), 64'(0));
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("flush no done", 64'(saw_done), 64'(0));
    check("flush hi kept", 64'(hi), 64'(model_hi));
    check("flush lo kept", 64'(lo), 64'(model_lo));

    // Start together with flush in IDLE is ignored
    start = 1'b1; flush = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start+flush ignored", 64'(busy), 64'(0));

    // MTLO/MFLO/start while busy stall and are dropped; MTLO after done lands
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd12; e.div0 = 1'b0;
      sb.push_back(e);
    end
    issue(2'b01, 32'd3, 32'd4);
    lo_we = 1'b1; wdata = 32'h0000_AAAA;
    #1;
    check("stall on MTLO", 64'(stall), 64'(1));
    @(posedge clk); #1;
    check("lo unchanged while busy", 64'(lo), 64'(model_lo));
    lo_we = 1'b0; rd_hilo = 1'b1;
    #1;
    check("stall on MFLO", 64'(stall), 64'(1));
    rd_hilo = 1'b0;
    start = 1'b1; op = 2'b11; rs_val = 32'd1; rt_val = 32'd1;
    #1;
    check("stall on start", 64'(stall), 64'(1));
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    model_hi = 32'd0; model_lo = 32'd12;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall op done seen", 64'(done), 64'(1));
    check("stall low in done cycle", 64'(busy), 64'(0));
    lo_we = 1'b1; wdata = 32'h0000_AAAA;
    #1;
    check("no stall when idle", 64'(stall), 64'(0));
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("MTLO after done", 64'(lo), 64'(32'h0000_AAAA));
    check("hi after MTLO", 64'(hi), 64'(model_hi));

    // Asynchronous reset mid-operation discards everything
    issue(2'b01, 32'd9, 32'd9);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid-op reset busy", 64'(busy), 64'(0));
    check("mid-op reset lo", 64'(lo), 64'(0));
    check("mid-op reset hi", 64'(hi), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end

    check("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO multiply/divide unit plus its sequencing controller for the pipelined MIPS core.
- Executes MULT, MULTU, DIV and DIVU in iterative radix-2 form.
- Owns the HI/LO registers and services MTHI/MTLO writes.
- Raises a pipeline stall while busy so the hazard logic holds any younger HI/LO consumer or a new mul/div instruction in EX.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX-stage mul/div issue, sampled on clk
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  multiplicand or dividend
- rt_val  in  WIDTH  multiplier or divisor
- flush  in  1  abort the current operation (exception or IRQ entry)
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- rd_hilo  in  1  EX instruction is MFHI/MFLO
- busy  out  1  operation in progress
- stall  out  1  busy & (start | rd_hilo | hi_we | lo_we)
- done  out  1  one-cycle pulse: HI/LO updated
- div0  out  1  pulses with done when a divide had a zero divisor
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, div0 = 0; hi, lo = 0; counter = 0.
  - Reset mid-operation discards all work.
- States: IDLE, CALC, FIX.
- IDLE, start=1 and flush=0 at edge k:
  - Latch op.
  - Convert operands to magnitudes; signed ops only (bit WIDTH-1 set → two's-complement negate).
  - Record result sign and dividend sign.
  - counter=WIDTH-1; state→CALC.
- CALC, multiply (shift-add), one iteration per edge:
  - If multiplier LSB is 1: acc(2·WIDTH) += mcand.
  - Then mcand <<= 1 and multiplier >>= 1.
- CALC, divide (restoring), one iteration per edge:
  - rem = {rem, quotient MSB}.
  - If rem ≥ divisor: subtract and set quotient bit to 1.
- CALC exit: counter decrements; at counter==0 the state moves to FIX on that edge. CALC therefore lasts exactly WIDTH edges.
- FIX, one edge, then →IDLE:
  - Signed multiply: negate the 2·WIDTH product if operand signs differed.
  - Signed divide: negate the quotient if signs differed; the remainder takes the dividend's sign.
  - Write {hi,lo} = product, or hi=remainder, lo=quotient.
  - done=1 for the following cycle.
- Timing: start at edge k → done high in the cycle after edge k+WIDTH+1. busy is high for cycles k+1 through k+WIDTH+1 and low in the done cycle. With WIDTH=32: 33 busy cycles.
- Divide by zero:
  - Skip CALC: IDLE→FIX directly.
  - hi=rs_val, lo=all ones, div0 pulses with done.
  - Latency is 2 edges.
- Signed overflow, 0x80000000 / -1: the magnitude path yields lo=0x80000000, hi=0. No flag.
- flush:
  - In any state, forces IDLE on the next edge.
  - No done; hi/lo keep their pre-operation values.
  - flush together with start in IDLE: start is ignored.
- start while busy: ignored. The stall output keeps the instruction in EX until the done cycle, where busy=0 and the start is accepted.
- hi_we/lo_we:
  - Honoured only when busy=0 (including the done cycle) and start=0.
  - When start and a write coincide, start wins and the write is dropped (the decoder never produces both).
- hi/lo hold their values between updates. MFHI/MFLO read them combinationally when stall=0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Enabled:
  - During multiply CALC, when the remaining multiplier register is zero after an iteration, go to FIX on the next edge regardless of the counter.
  - A zero multiplier at start goes directly IDLE→FIX.
  - Divide timing is unchanged.
- Disabled: fixed WIDTH-edge CALC for all operations.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after start, busy high for 33 cycles.
- MULT -3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MULDIV_EARLY_OUT_EN, done arrives after ≤5 cycles.
- DIV -7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100 ÷ 0 → div0=1 with done 2 cycles after start, hi=0x00000064, lo=0xFFFFFFFF.
- Preload hi=0x1234 via MTHI, start MULTU, assert flush at cycle 10 → no done, busy low next cycle, hi=0x1234.
- MTLO 0xAAAA and MFLO while busy → stall=1, lo unchanged. Repeat MTLO after done → lo=0x0000AAAA.
